// File: rtl/registers_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : registers_mp_if
//  Description : Read/write/reservation bus of the multi-port register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface registers_mp_if #(
    parameter int AddressBitWidth = 5,
    parameter int DataBitWidth    = 32,
    parameter int NumReadPorts    = 2
);
    logic                                    ready;
    logic [NumReadPorts*AddressBitWidth-1:0] rs_addr;
    logic [NumReadPorts*DataBitWidth-1:0]    rs_data;
    logic [NumReadPorts-1:0]                 rs_pending;
    logic [AddressBitWidth-1:0]              rd;
    logic                                    rd_write_enable;
    logic [DataBitWidth-1:0]                 rd_data_in;
    logic [AddressBitWidth-1:0]              rsv;
    logic                                    rsv_enable;

    modport master (
        input  ready, rs_data, rs_pending,
        output rs_addr, rd, rd_write_enable, rd_data_in, rsv, rsv_enable
    );

    modport slave (
        output ready, rs_data, rs_pending,
        input  rs_addr, rd, rd_write_enable, rd_data_in, rsv, rsv_enable
    );
endinterface
`default_nettype wire

// File: rtl/registers_mp.sv
`default_nettype none
// ============================================================================
//  Module      : registers_mp
//  Description : Multi-read-port register file with pending-bit scoreboard,
//                write bypass and a post-reset clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module registers_mp #(
    parameter int AddressBitWidth  = 5,
    parameter int DataBitWidth     = 32,
    parameter int NumReadPorts     = 2,
    parameter int ZeroRegHardwired = 1,
    parameter int BypassEnable     = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    registers_mp_if.slave     bus
);
    localparam int c_num_regs = 2 ** AddressBitWidth;

    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_run   = 1'b1;

    logic [0:0]                 r_state;
    logic [0:0]                 w_next_state;
    logic                       w_ready;
    logic [AddressBitWidth-1:0] r_counter;
    logic [DataBitWidth-1:0]    r_data [c_num_regs];
    logic [c_num_regs-1:0]      r_pending;
    logic                       w_write_ok;
    logic                       w_rsv_ok;

    logic [NumReadPorts*DataBitWidth-1:0] w_rs_data;
    logic [NumReadPorts-1:0]              w_rs_pending;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_clear;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: the write to the last index completes before RUN
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_clear: if (r_counter == '1) w_next_state = c_st_run;
            c_st_run:   w_next_state = c_st_run;
            default:    w_next_state = c_st_clear;
        endcase
    end

    // Output logic
    always_comb begin
        w_ready = (r_state == c_st_run);
    end

    assign w_write_ok = w_ready && bus.rd_write_enable
                        && !((ZeroRegHardwired != 0) && (bus.rd == '0));
    assign w_rsv_ok   = w_ready && bus.rsv_enable
                        && !((ZeroRegHardwired != 0) && (bus.rsv == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter <= '0;
        end else if (r_state == c_st_clear) begin
            r_counter <= r_counter + 1'b1;
        end
    end

    // The array is zeroed by the sequencer, one entry per cycle, not by rst
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_st_clear) begin
                r_data[r_counter] <= '0;
            end else if (w_write_ok) begin
                r_data[bus.rd] <= bus.rd_data_in;
            end
        end
    end

    // Set after clear so a same-cycle reservation survives the write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (w_write_ok) r_pending[bus.rd]  <= 1'b0;
            if (w_rsv_ok)   r_pending[bus.rsv] <= 1'b1;
        end
    end

    always_comb begin
        w_rs_data    = '0;
        w_rs_pending = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            if (!w_ready) begin
                w_rs_data[p*DataBitWidth +: DataBitWidth] = '0;
                w_rs_pending[p]                           = 1'b0;
            end else if ((ZeroRegHardwired != 0)
                         && (bus.rs_addr[p*AddressBitWidth +: AddressBitWidth] == '0)) begin
                w_rs_data[p*DataBitWidth +: DataBitWidth] = '0;
                w_rs_pending[p]                           = 1'b0;
            end else if ((BypassEnable != 0) && bus.rd_write_enable
                         && (bus.rs_addr[p*AddressBitWidth +: AddressBitWidth] == bus.rd)) begin
                w_rs_data[p*DataBitWidth +: DataBitWidth] = bus.rd_data_in;
                w_rs_pending[p]                           = 1'b0;
            end else begin
                w_rs_data[p*DataBitWidth +: DataBitWidth] =
                    r_data[bus.rs_addr[p*AddressBitWidth +: AddressBitWidth]];
                w_rs_pending[p] =
                    r_pending[bus.rs_addr[p*AddressBitWidth +: AddressBitWidth]];
            end
        end
    end

    assign bus.ready      = w_ready;
    assign bus.rs_data    = w_rs_data;
    assign bus.rs_pending = w_rs_pending;

endmodule
`default_nettype wire

// File: tb/tb_registers_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_registers_mp
//  Description : Self-checking bench for registers_mp (vector table, directed
//                reset sequences, randomized traffic against a reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_registers_mp;
    localparam int c_aw   = 5;
    localparam int c_dw   = 32;
    localparam int c_regs = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    registers_mp_if #(.AddressBitWidth(c_aw), .DataBitWidth(c_dw), .NumReadPorts(2)) bus ();

    registers_mp #(
        .AddressBitWidth (c_aw),
        .DataBitWidth    (c_dw),
        .NumReadPorts    (2),
        .ZeroRegHardwired(1),
        .BypassEnable    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register contents, pending flags, cycles of clearing done
    logic [31:0] m_data [c_regs];
    bit          m_pend [c_regs];
    int          m_clear_cnt = 0;

    logic [4:0]  a0, a1;

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] din;
        bit          rsv_en;
        logic [4:0]  rsv;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          p0;
        bit          p1;
    } vec_t;

    vec_t tbl [15];

    function automatic bit m_ready();
        return m_clear_cnt >= c_regs;
    endfunction

    task automatic m_read(input logic [4:0] a, output logic [31:0] d, output bit p);
        if (!m_ready() || a == 5'd0) begin
            d = 32'd0; p = 1'b0;
        end else if (bus.rd_write_enable && a == bus.rd) begin
            d = bus.rd_data_in; p = 1'b0;
        end else begin
            d = m_data[a]; p = m_pend[a];
        end
    endtask

    task automatic drive(input bit we, input logic [4:0] rd, input logic [31:0] din,
                         input bit rsv_en, input logic [4:0] rsv,
                         input logic [4:0] x0, input logic [4:0] x1);
        bus.rd_write_enable = we;
        bus.rd              = rd;
        bus.rd_data_in      = din;
        bus.rsv_enable      = rsv_en;
        bus.rsv             = rsv;
        a0                  = x0;
        a1                  = x1;
        bus.rs_addr         = {x1, x0};
    endtask

    task automatic cmp32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cmp1(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] d;
        bit          p;
        #2;
        cmp1({tag, " ready"}, bus.ready, m_ready());
        m_read(a0, d, p);
        cmp32({tag, " port0 data"}, bus.rs_data[31:0], d);
        cmp1({tag, " port0 pending"}, bus.rs_pending[0], p);
        m_read(a1, d, p);
        cmp32({tag, " port1 data"}, bus.rs_data[63:32], d);
        cmp1({tag, " port1 pending"}, bus.rs_pending[1], p);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_clear_cnt = 0;
            for (int i = 0; i < c_regs; i++) begin
                m_data[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
        end else if (!m_ready()) begin
            m_clear_cnt++;
        end else begin
            if (bus.rd_write_enable && bus.rd != 5'd0) begin
                m_data[bus.rd] = bus.rd_data_in;
                m_pend[bus.rd] = 1'b0;
            end
            if (bus.rsv_enable && bus.rsv != 5'd0) m_pend[bus.rsv] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(3, 0) == 0) return 5'($urandom_range(31, 0));
        return 5'($urandom_range(7, 0));
    endfunction

    task automatic drive_random();
        drive(1'($urandom_range(1, 0)), rand_addr(), $urandom(),
              1'($urandom_range(1, 0)), rand_addr(), rand_addr(), rand_addr());
    endtask

    // Random traffic while clearing; counts posedges until ready rises
    task automatic wait_clear(input string tag);
        int cnt = 0;
        while (!bus.ready && cnt < 64) begin
            drive_random();
            check_model(tag);
            tick();
            cnt++;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (cnt != c_regs) begin
            n_err++;
            $display("FAIL %s ready latency: got %0d cycles expected %0d", tag, cnt, c_regs);
        end
    endtask

    initial begin
        tbl[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        tbl[1]  = '{0, 5'd0,  32'h0,        0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        tbl[2]  = '{1, 5'd0,  32'h1234,     1, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        0, 0};
        tbl[3]  = '{0, 5'd0,  32'h0,        0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        0, 0};
        tbl[4]  = '{0, 5'd0,  32'h0,        1, 5'd7, 5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 0, 0};
        tbl[5]  = '{0, 5'd0,  32'h0,        0, 5'd0, 5'd7,  5'd7,  32'h0,        32'h0,        1, 1};
        tbl[6]  = '{1, 5'd7,  32'h55,       0, 5'd0, 5'd7,  5'd7,  32'h55,       32'h55,       0, 0};
        tbl[7]  = '{0, 5'd0,  32'h0,        0, 5'd0, 5'd7,  5'd0,  32'h55,       32'h0,        0, 0};
        tbl[8]  = '{1, 5'd9,  32'hAA,       1, 5'd9, 5'd9,  5'd9,  32'hAA,       32'hAA,       0, 0};
        tbl[9]  = '{0, 5'd0,  32'h0,        0, 5'd0, 5'd9,  5'd9,  32'hAA,       32'hAA,       1, 1};
        tbl[10] = '{0, 5'd0,  32'h0,        1, 5'd9, 5'd9,  5'd7,  32'hAA,       32'h55,       1, 0};
        tbl[11] = '{0, 5'd0,  32'h0,        0, 5'd0, 5'd9,  5'd0,  32'hAA,       32'h0,        1, 0};
        tbl[12] = '{1, 5'd3,  32'h1,        0, 5'd0, 5'd3,  5'd31, 32'h1,        32'h0,        0, 0};
        tbl[13] = '{1, 5'd31, 32'hFFFFFFFF, 0, 5'd0, 5'd3,  5'd31, 32'h1,        32'hFFFFFFFF, 0, 0};
        tbl[14] = '{0, 5'd0,  32'h0,        0, 5'd0, 5'd31, 5'd3,  32'hFFFFFFFF, 32'h1,        0, 0};

        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_clear("initial clear");

        for (int r = 0; r < c_regs; r += 2) begin
            drive(0, 0, 0, 0, 0, 5'(r), 5'(r + 1));
            check_model("post-clear read");
            cmp32("post-clear zero port0", bus.rs_data[31:0], 32'd0);
            cmp32("post-clear zero port1", bus.rs_data[63:32], 32'd0);
            tick();
        end

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].we, tbl[i].rd, tbl[i].din, tbl[i].rsv_en, tbl[i].rsv, tbl[i].a0, tbl[i].a1);
            #2;
            cmp32($sformatf("vec%0d port0 data", i), bus.rs_data[31:0], tbl[i].d0);
            cmp32($sformatf("vec%0d port1 data", i), bus.rs_data[63:32], tbl[i].d1);
            cmp1($sformatf("vec%0d port0 pending", i), bus.rs_pending[0], tbl[i].p0);
            cmp1($sformatf("vec%0d port1 pending", i), bus.rs_pending[1], tbl[i].p1);
            tick();
        end

        // x3 holds 1 from the table; a reset in RUN must re-clear it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear("reset in run");
        drive(0, 0, 0, 0, 0, 5'd3, 5'd31);
        #2;
        cmp32("x3 after rerun clear", bus.rs_data[31:0], 32'd0);
        cmp32("x31 after rerun clear", bus.rs_data[63:32], 32'd0);
        tick();

        for (int i = 0; i < 400; i++) begin
            drive_random();
            check_model("random");
            tick();
        end

        // Reset lands while the clear counter sits at 10
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_random();
            check_model("partial clear");
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear("reset mid-clear");

        for (int i = 0; i < 100; i++) begin
            drive_random();
            check_model("random after restart");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
